nano_fetch_unit: RTL



---
 rtl/nano_pkg.sv | 16 +
 rtl/nano_fetch_unit_if.sv | 47 ++++
 rtl/nano_skid_fifo.sv | 62 ++++++
 rtl/nano_fetch_unit.sv | 111 +++++++++++
 4 files changed

// File: rtl/nano_pkg.sv
// Shared widths, reset PC and the fetch-entry payload for the NanoRisc fetch stage.
package nano_pkg;

  localparam int unsigned NANO_ADDR_WIDTH  = 8;
  localparam int unsigned NANO_INSTR_WIDTH = 8;
  localparam int unsigned NANO_RESET_PC    = 0;
  localparam int unsigned FIFO_DEPTH       = 2;
  localparam int unsigned FIFO_COUNT_WIDTH = 2;
  localparam int unsigned PERF_COUNT_WIDTH = 16;

  typedef struct packed {
    logic [NANO_INSTR_WIDTH-1:0] instruction;
    logic [NANO_ADDR_WIDTH-1:0]  pc;
  } fetchEntry_t;

endpackage

// File: rtl/nano_fetch_unit_if.sv
// Fetch-stage bus: redirect input, InstructionMemory read port and decode handshake.
// FETCH_PERF_COUNT_EN adds the fetchCount/stallCount signals.
interface nano_fetch_unit_if
  import nano_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = NANO_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = NANO_INSTR_WIDTH
) ();

  logic                   redirectValid;
  logic [ADDR_WIDTH-1:0]  redirectAddress;
  logic                   imemReadEnable;
  logic [ADDR_WIDTH-1:0]  imemAddress;
  logic [INSTR_WIDTH-1:0] imemInstruction;
  logic                   instrValid;
  logic                   instrReady;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [ADDR_WIDTH-1:0]  instrPc;

`ifdef FETCH_PERF_COUNT_EN
  logic [PERF_COUNT_WIDTH-1:0] fetchCount;
  logic [PERF_COUNT_WIDTH-1:0] stallCount;

  modport master (
    input  redirectValid, redirectAddress, imemInstruction, instrReady,
    output imemReadEnable, imemAddress, instrValid, instruction, instrPc,
           fetchCount, stallCount
  );

  modport slave (
    output redirectValid, redirectAddress, imemInstruction, instrReady,
    input  imemReadEnable, imemAddress, instrValid, instruction, instrPc,
           fetchCount, stallCount
  );
`else
  modport master (
    input  redirectValid, redirectAddress, imemInstruction, instrReady,
    output imemReadEnable, imemAddress, instrValid, instruction, instrPc
  );

  modport slave (
    output redirectValid, redirectAddress, imemInstruction, instrReady,
    input  imemReadEnable, imemAddress, instrValid, instruction, instrPc
  );
`endif

endinterface

// File: rtl/nano_skid_fifo.sv
// Two-entry FIFO of fetch entries with a registered head; flush empties it.
module nano_skid_fifo
  import nano_pkg::*;
#(
  parameter type entryT = fetchEntry_t
) (
  input  logic                        clock,
  input  logic                        resetN,
  input  logic                        push,
  input  entryT                       pushEntry,
  input  logic                        pop,
  input  logic                        flush,
  output entryT                       headEntry,
  output logic [FIFO_COUNT_WIDTH-1:0] count
);

  entryT                       slot0Q, slot0D;
  entryT                       slot1Q, slot1D;
  logic [FIFO_COUNT_WIDTH-1:0] countQ, countD;
  logic                        pushToSlot0;

  // A push lands behind whatever survives this cycle's pop.
  assign pushToSlot0 = (countQ == FIFO_COUNT_WIDTH'(0)) ||
                       ((countQ == FIFO_COUNT_WIDTH'(1)) && pop);

  always_comb begin
    slot0D = slot0Q;
    slot1D = slot1Q;
    countD = countQ;
    if (flush) begin
      countD = '0;
    end else begin
      if (pop) begin
        slot0D = slot1Q;
      end
      if (push) begin
        if (pushToSlot0) begin
          slot0D = pushEntry;
        end else begin
          slot1D = pushEntry;
        end
      end
      countD = countQ + FIFO_COUNT_WIDTH'(push) - FIFO_COUNT_WIDTH'(pop);
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      slot0Q <= '0;
      slot1Q <= '0;
      countQ <= '0;
    end else begin
      slot0Q <= slot0D;
      slot1Q <= slot1D;
      countQ <= countD;
    end
  end

  assign headEntry = slot0Q;
  assign count     = countQ;

endmodule

// File: rtl/nano_fetch_unit.sv
// NanoRisc fetch stage: owns the PC, issues one InstructionMemory read per cycle and buffers
// responses in a 2-entry skid FIFO. FETCH_PERF_COUNT_EN adds pop/stall counters.
module nano_fetch_unit
  import nano_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = NANO_ADDR_WIDTH,
  parameter int unsigned           INSTR_WIDTH = NANO_INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(NANO_RESET_PC)
) (
  input logic               clock,
  input logic               resetN,
  nano_fetch_unit_if.master fetchBus
);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instruction;
    logic [ADDR_WIDTH-1:0]  pc;
  } entryT;

  logic [ADDR_WIDTH-1:0]       fetchPcQ, fetchPcD;
  logic [ADDR_WIDTH-1:0]       inFlightPcQ, inFlightPcD;
  logic                        inFlightQ, inFlightD;
  logic [FIFO_COUNT_WIDTH-1:0] fifoCount;
  logic [2:0]                  occupancy;
  logic                        instrValidInt;
  logic                        pop;
  logic                        push;
  logic                        issue;
  entryT                       pushEntry;
  entryT                       headEntry;

  assign instrValidInt = (fifoCount != FIFO_COUNT_WIDTH'(0));
  assign pop           = instrValidInt & fetchBus.instrReady;
  // A response arriving in a redirect cycle belongs to the abandoned path.
  assign push          = inFlightQ & ~fetchBus.redirectValid;
  assign occupancy     = 3'(fifoCount) + 3'(inFlightQ) - 3'(pop);
  assign issue         = resetN & ~fetchBus.redirectValid & (occupancy < 3'd2);
  assign pushEntry     = '{instruction: fetchBus.imemInstruction, pc: inFlightPcQ};

  // Next PC and in-flight tracking; redirect outranks issue.
  always_comb begin
    fetchPcD    = fetchPcQ;
    inFlightD   = 1'b0;
    inFlightPcD = inFlightPcQ;
    if (fetchBus.redirectValid) begin
      fetchPcD = fetchBus.redirectAddress;
    end else if (issue) begin
      fetchPcD    = fetchPcQ + ADDR_WIDTH'(1);
      inFlightD   = 1'b1;
      inFlightPcD = fetchPcQ;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      fetchPcQ    <= RESET_PC;
      inFlightQ   <= 1'b0;
      inFlightPcQ <= '0;
    end else begin
      fetchPcQ    <= fetchPcD;
      inFlightQ   <= inFlightD;
      inFlightPcQ <= inFlightPcD;
    end
  end

  nano_skid_fifo #(
    .entryT (entryT)
  ) skidFifo (
    .clock     (clock),
    .resetN    (resetN),
    .push      (push),
    .pushEntry (pushEntry),
    .pop       (pop),
    .flush     (fetchBus.redirectValid),
    .headEntry (headEntry),
    .count     (fifoCount)
  );

  assign fetchBus.imemReadEnable = issue;
  assign fetchBus.imemAddress    = fetchPcQ;
  assign fetchBus.instrValid     = instrValidInt;
  assign fetchBus.instruction    = headEntry.instruction;
  assign fetchBus.instrPc        = headEntry.pc;

`ifdef FETCH_PERF_COUNT_EN
  logic [PERF_COUNT_WIDTH-1:0] fetchCountQ;
  logic [PERF_COUNT_WIDTH-1:0] stallCountQ;
  logic                        stall;

  assign stall = instrValidInt & ~fetchBus.instrReady;

  // Saturating counters of accepted instructions and decode stall cycles.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      fetchCountQ <= '0;
      stallCountQ <= '0;
    end else begin
      if (pop && (fetchCountQ != '1)) begin
        fetchCountQ <= fetchCountQ + PERF_COUNT_WIDTH'(1);
      end
      if (stall && (stallCountQ != '1)) begin
        stallCountQ <= stallCountQ + PERF_COUNT_WIDTH'(1);
      end
    end
  end

  assign fetchBus.fetchCount = fetchCountQ;
  assign fetchBus.stallCount = stallCountQ;
`endif

endmodule
